// File: rtl/seg_scan_if.sv
// seg_scan_if: value/load/dec request and busy/seg display bundle for seg_scan_driver.
interface seg_scan_if;
    logic [25:0] value;
    logic        load;
    logic        dec;
    logic        busy;
    logic [11:0] seg;
    modport master (output value, load, dec, input busy, seg);
    modport slave  (input value, load, dec, output busy, seg);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment driver, hex or sequential double-dabble decimal.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits (digit0 always shown).
module seg_scan_driver #(
    parameter int SCAN_DIV  = 65536,
    parameter int CONV_BITS = 14
) (
    input logic       mclk,
    input logic       rst_n,
    seg_scan_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(CONV_BITS + 1);

    typedef enum logic {IDLE, CONV} state_t;
    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [1:0]           r_idx;
    logic [11:0]          r_seg;
    logic [15:0]          r_disp;
    logic                 r_dash;
    logic [CONV_BITS-1:0] r_bin;
    logic [15:0]          r_bcd;
    logic [BW-1:0]        r_bits;
    logic [15:0]          w_adj, w_shift;
    logic [3:0]           w_nib, w_blank;
    logic [7:0]           w_code;
    logic                 w_too_big, w_start, w_last, w_wrap;

    assign w_too_big = bus.value > 26'd9999;
    assign w_start   = bus.load && bus.dec && !w_too_big;
    assign w_last    = r_bits == BW'(CONV_BITS - 1);
    assign w_wrap    = r_cnt == CW'(SCAN_DIV - 1);

    always_ff @(posedge mclk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb
        w_next = (r_state == IDLE) ? (w_start ? CONV : IDLE) : (w_last ? IDLE : CONV);

    always_comb
        bus.busy = r_state == CONV;

    // add-3 correction on every BCD nibble before it is shifted
    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
    end
    assign w_shift = {w_adj[14:0], r_bin[CONV_BITS-1]};

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_dash <= 1'b0;
            r_bin  <= '0;
            r_bcd  <= '0;
            r_bits <= '0;
        end else if (r_state == IDLE) begin
            if (bus.load && !bus.dec) begin
                r_disp <= bus.value[15:0];
                r_dash <= 1'b0;
            end else if (bus.load && w_too_big) begin
                r_dash <= 1'b1;
            end else if (w_start) begin
                r_bin  <= bus.value[CONV_BITS-1:0];
                r_bcd  <= '0;
                r_bits <= '0;
            end
        end else begin
            r_bin  <= r_bin << 1;
            r_bcd  <= w_shift;
            r_bits <= r_bits + 1'b1;
            if (w_last) begin
                r_disp <= w_shift;
                r_dash <= 1'b0;
            end
        end
    end

    assign w_nib = r_disp[4*r_idx +: 4];

    always_comb begin
        w_blank = '0;
`ifdef LEAD_ZERO_BLANK_EN
        w_blank[3] = r_disp[15:12] == 4'd0;
        w_blank[2] = w_blank[3] && r_disp[11:8] == 4'd0;
        w_blank[1] = w_blank[2] && r_disp[7:4] == 4'd0;
`endif
    end

    always_comb begin
        case (w_nib)
            4'h0: w_code = 8'hC0;
            4'h1: w_code = 8'hF9;
            4'h2: w_code = 8'hA4;
            4'h3: w_code = 8'hB0;
            4'h4: w_code = 8'h99;
            4'h5: w_code = 8'h92;
            4'h6: w_code = 8'h82;
            4'h7: w_code = 8'hF8;
            4'h8: w_code = 8'h80;
            4'h9: w_code = 8'h90;
            4'hA: w_code = 8'h88;
            4'hB: w_code = 8'h83;
            4'hC: w_code = 8'hC6;
            4'hD: w_code = 8'hA1;
            4'hE: w_code = 8'h86;
            default: w_code = 8'h8E;
        endcase
        w_code = r_dash ? 8'hBF : (w_blank[r_idx] ? 8'hFF : w_code);
    end

    // scan runs free of the FSM; load never touches it
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_seg <= 12'hFFF;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_idx <= w_wrap ? r_idx + 1'b1 : r_idx;
            r_seg <= {~(4'b0001 << r_idx), w_code};
        end
    end

    assign bus.seg = r_seg;
endmodule
